// File: rtl/config_loader_pkg.sv
// Shared types and CRC-16 helpers for the configuration loader.
package config_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_CRC      = 3'd2,
      ST_DONE     = 3'd3,
      ST_ERROR    = 3'd4,
      ST_READBACK = 3'd5
   } state_t;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   // One serial CRC-16 step, MSB-first.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      logic fb;
      fb = crc[15] ^ din;
      return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/config_loader_crc16.sv
// LANES-wide parallel CRC-16 update; data[LANES-1] is consumed first.
module config_crc16
   import config_loader_pkg::*;
#(
   parameter int LANES = 1
) (
   input  logic [15:0]      crc_in,
   input  logic [LANES-1:0] data,
   output logic [15:0]      crc_out
);

   // Chain LANES serial steps, earliest stream bit first.
   always_comb begin
      crc_out = crc_in;
      for (int i = LANES - 1; i >= 0; i--) begin
         crc_out = crc16_step(crc_out, data[i]);
      end
   end

endmodule

// File: rtl/config_loader.sv
// Configuration loader: streams the image in LANES bits per beat, optionally
// checks a CRC-16 trailer, enables the core, and supports rotating readback.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | waiting for start, input ignored
// ST_LOAD     | shifting payload beats into config_data
// ST_CRC      | collecting the 16-bit trailer, image and crc frozen
// ST_DONE     | image valid, core enabled
// ST_ERROR    | trailer mismatch, image kept for debug
// ST_READBACK | rotating image out on rb_data, restored after a full pass
module config_loader
   import config_loader_pkg::*;
#(
   parameter int CONFIG_WIDTH = 34688,
   parameter int LANES        = 1,
   parameter int CRC_EN       = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    in_valid,
   input  logic [LANES-1:0]        in_data,
   output logic                    in_ready,
   input  logic                    rb_start,
   output logic                    rb_valid,
   output logic [LANES-1:0]        rb_data,
   input  logic                    rb_ready,
   output logic [CONFIG_WIDTH-1:0] config_data,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic                    core_enable
);

   localparam int BEATS     = CONFIG_WIDTH / LANES;
   localparam int CNT_W     = $clog2(BEATS + 1);
   localparam int CRC_BEATS = 16 / LANES;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] beat_cnt;
   logic [3:0]       crc_cnt;
   logic [15:0]      crc;
   logic [15:0]      crc_rx;
   logic [15:0]      crc_upd;
   logic             in_xfer;
   logic             rb_xfer;
   logic             beat_last;
   logic             crc_last;
   logic             crc_ok;

   config_crc16 #(.LANES(LANES)) u_crc (
      .crc_in  (crc),
      .data    (in_data),
      .crc_out (crc_upd)
   );

   // Outputs decode the state register only, so in_ready never depends on in_valid.
   assign in_ready    = (state == ST_LOAD) || (state == ST_CRC);
   assign busy        = (state == ST_LOAD) || (state == ST_CRC) || (state == ST_READBACK);
   assign done        = (state == ST_DONE);
   assign error       = (state == ST_ERROR);
   assign core_enable = (state == ST_DONE);
   assign rb_valid    = (state == ST_READBACK);
   assign rb_data     = config_data[CONFIG_WIDTH-1 -: LANES];

   assign in_xfer   = in_valid && in_ready;
   assign rb_xfer   = rb_valid && rb_ready;
   assign beat_last = (beat_cnt == CNT_W'(BEATS - 1));
   assign crc_last  = (crc_cnt == 4'(CRC_BEATS - 1));
   // The final trailer beat is compared before it is registered.
   assign crc_ok    = (crc == 16'({crc_rx, in_data}));

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode; start wins over everything else, including a coincident beat.
   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = ST_LOAD;
      end else begin
         case (state)
            ST_LOAD:     if (in_valid && beat_last) state_nxt = (CRC_EN != 0) ? ST_CRC : ST_DONE;
            ST_CRC:      if (in_valid && crc_last)  state_nxt = crc_ok ? ST_DONE : ST_ERROR;
            ST_DONE:     if (rb_start)              state_nxt = ST_READBACK;
            ST_READBACK: if (rb_ready && beat_last) state_nxt = ST_DONE;
            default:     state_nxt = state;
         endcase
      end
   end

   // Image, counters and CRC; start clears on the same edge that samples it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         config_data <= '0;
         beat_cnt    <= '0;
         crc_cnt     <= '0;
         crc         <= CRC_INIT;
         crc_rx      <= '0;
      end else if (start) begin
         config_data <= '0;
         beat_cnt    <= '0;
         crc_cnt     <= '0;
         crc         <= CRC_INIT;
         crc_rx      <= '0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (in_xfer) begin
                  config_data <= CONFIG_WIDTH'({config_data, in_data});
                  crc         <= crc_upd;
                  beat_cnt    <= beat_cnt + CNT_W'(1);
               end
            end
            ST_CRC: begin
               if (in_xfer) begin
                  crc_rx  <= 16'({crc_rx, in_data});
                  crc_cnt <= crc_cnt + 4'd1;
               end
            end
            ST_DONE: begin
               if (rb_start) beat_cnt <= '0;
            end
            ST_READBACK: begin
               if (rb_xfer) begin
                  config_data <= CONFIG_WIDTH'({config_data, config_data[CONFIG_WIDTH-1 -: LANES]});
                  beat_cnt    <= beat_cnt + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: behavioural model for a 16x4 CRC instance checked
// every cycle, directed checks on a no-CRC twin, and a full-size LANES=1 load.
module tb_config_loader;

   localparam int M_IDLE = 0, M_LOAD = 1, M_CRC = 2, M_DONE = 3, M_ERR = 4, M_RB = 5;
   localparam int BIG_W  = 34688;

   logic clock = 1'b0;
   logic reset = 1'b0;

   logic       start = 1'b0, in_valid = 1'b0, rb_start = 1'b0, rb_ready = 1'b0;
   logic [3:0] in_data = 4'h0;

   logic        d1_in_ready, d1_rb_valid, d1_busy, d1_done, d1_error, d1_core_enable;
   logic [3:0]  d1_rb_data;
   logic [15:0] d1_config;
   logic        d0_in_ready, d0_rb_valid, d0_busy, d0_done, d0_error, d0_core_enable;
   logic [3:0]  d0_rb_data;
   logic [15:0] d0_config;

   logic             bg_start = 1'b0, bg_valid = 1'b0, bg_data = 1'b0;
   logic             bg_rb_start = 1'b0, bg_rb_ready = 1'b0;
   logic             bg_in_ready, bg_rb_valid, bg_rb_data, bg_busy, bg_done, bg_error, bg_core_enable;
   logic [BIG_W-1:0] bg_config;
   logic [BIG_W-1:0] exp_big = '0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   config_loader #(.CONFIG_WIDTH(16), .LANES(4), .CRC_EN(1)) dut_c (
      .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(d1_in_ready), .rb_start(rb_start), .rb_valid(d1_rb_valid), .rb_data(d1_rb_data),
      .rb_ready(rb_ready), .config_data(d1_config), .busy(d1_busy), .done(d1_done),
      .error(d1_error), .core_enable(d1_core_enable)
   );

   config_loader #(.CONFIG_WIDTH(16), .LANES(4), .CRC_EN(0)) dut_n (
      .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(d0_in_ready), .rb_start(rb_start), .rb_valid(d0_rb_valid), .rb_data(d0_rb_data),
      .rb_ready(rb_ready), .config_data(d0_config), .busy(d0_busy), .done(d0_done),
      .error(d0_error), .core_enable(d0_core_enable)
   );

   config_loader dut_big (
      .clock(clock), .reset(reset), .start(bg_start), .in_valid(bg_valid), .in_data(bg_data),
      .in_ready(bg_in_ready), .rb_start(bg_rb_start), .rb_valid(bg_rb_valid), .rb_data(bg_rb_data),
      .rb_ready(bg_rb_ready), .config_data(bg_config), .busy(bg_busy), .done(bg_done),
      .error(bg_error), .core_enable(bg_core_enable)
   );

   // Textbook CRC-16 (poly 0x1021, MSB first) over the low n bits of v.
   function automatic logic [15:0] crc_bits(input logic [15:0] c, input logic [63:0] v, input int n);
      logic [15:0] r;
      r = c;
      for (int i = n - 1; i >= 0; i--) begin
         if (r[15] ^ v[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
         else              r = {r[14:0], 1'b0};
      end
      return r;
   endfunction

   function automatic logic [15:0] rotl4(input logic [15:0] v, input int k);
      logic [31:0] d;
      d = {v, v};
      return d[31 - 4*k -: 16];
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Model of the 16x4 CRC instance: image as a word, beat counts, readback index.
   int          md_mode = M_IDLE, md_n = 0, md_tn = 0, md_rbi = 0;
   logic [15:0] md_img = '0, md_trl = '0;

   // Model update on each edge, reset asynchronously like the design.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         md_mode <= M_IDLE; md_img <= '0; md_trl <= '0; md_n <= 0; md_tn <= 0; md_rbi <= 0;
      end else if (start) begin
         md_mode <= M_LOAD; md_img <= '0; md_trl <= '0; md_n <= 0; md_tn <= 0;
      end else begin
         case (md_mode)
            M_LOAD: if (in_valid) begin
               md_img <= {md_img[11:0], in_data};
               md_n   <= md_n + 1;
               if (md_n == 3) md_mode <= M_CRC;
            end
            M_CRC: if (in_valid) begin
               md_trl <= {md_trl[11:0], in_data};
               md_tn  <= md_tn + 1;
               if (md_tn == 3)
                  md_mode <= ({md_trl[11:0], in_data} == crc_bits(16'hFFFF, 64'(md_img), 16)) ? M_DONE : M_ERR;
            end
            M_DONE: if (rb_start) begin
               md_mode <= M_RB; md_rbi <= 0;
            end
            M_RB: if (rb_ready) begin
               if (md_rbi == 3) begin md_mode <= M_DONE; md_rbi <= 0; end
               else md_rbi <= md_rbi + 1;
            end
            default: ;
         endcase
      end
   end

   // Every-cycle comparison of the CRC instance against the model.
   always @(negedge clock) begin
      chk("in_ready",    64'(d1_in_ready),    64'(md_mode == M_LOAD || md_mode == M_CRC));
      chk("busy",        64'(d1_busy),        64'(md_mode == M_LOAD || md_mode == M_CRC || md_mode == M_RB));
      chk("done",        64'(d1_done),        64'(md_mode == M_DONE));
      chk("error",       64'(d1_error),       64'(md_mode == M_ERR));
      chk("core_enable", 64'(d1_core_enable), 64'(md_mode == M_DONE));
      chk("rb_valid",    64'(d1_rb_valid),    64'(md_mode == M_RB));
      chk("config_data", 64'(d1_config),      64'((md_mode == M_RB) ? rotl4(md_img, md_rbi) : md_img));
      if (md_mode == M_RB) chk("rb_data", 64'(d1_rb_data), 64'(md_img[15 - 4*md_rbi -: 4]));
   end

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
      #1;
   endtask

   task automatic step(input logic s, input logic v, input logic [3:0] d, input logic rbs, input logic rbr);
      start = s; in_valid = v; in_data = d; rb_start = rbs; rb_ready = rbr;
      tick();
   endtask

   initial begin
      logic [15:0] c;
      logic [15:0] cw;
      logic [15:0] cb;
      logic [3:0]  nib [4];
      logic [3:0]  d;
      logic        v;
      logic        b;

      nib = '{4'hA, 4'hB, 4'hC, 4'hD};

      #2 reset = 1'b1;
      tick();
      chk("rst_cfg",      64'(d1_config), 64'h0);
      chk("rst_ready",    64'(d1_in_ready), 64'h0);
      chk("rst_done",     64'(d1_done), 64'h0);
      chk("rst_core_en",  64'(d1_core_enable), 64'h0);
      chk("rst_big_busy", 64'(bg_busy), 64'h0);
      reset = 1'b0;

      // Pin the model's CRC and rotation helpers to known values.
      c = 16'hFFFF;
      for (int i = 0; i < 9; i++) c = crc_bits(c, 64'(8'h31 + i), 8);
      chk("model_crc_pin", 64'(c), 64'h29B1);
      chk("model_rot_pin", 64'(rotl4(16'hABCD, 1)), 64'hBCDA);

      // Plain load on both 16x4 instances.
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, nib[i], 0, 0);
         if (i < 3) chk("nc_done_early", 64'(d0_done), 64'h0);
      end
      chk("nc_cfg",      64'(d0_config), 64'hABCD);
      chk("nc_done",     64'(d0_done), 64'h1);
      chk("nc_core_en",  64'(d0_core_enable), 64'h1);
      chk("nc_ready",    64'(d0_in_ready), 64'h0);
      chk("nc_rb_valid", 64'(d0_rb_valid), 64'h0);
      chk("nc_rb_data",  64'(d0_rb_data), 64'hA);

      c = crc_bits(16'hFFFF, 64'h0000_0000_0000_ABCD, 16);
      for (int i = 0; i < 4; i++) step(0, 1, c[15 - 4*i -: 4], 0, 0);
      chk("crc_done", 64'(d1_done), 64'h1);
      chk("crc_cfg",  64'(d1_config), 64'hABCD);

      // Readback with a three-cycle stall on beat 2.
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         chk("rb_seq", 64'(d1_rb_data), 64'(nib[i]));
         if (i == 1) begin
            for (int s = 0; s < 3; s++) begin
               step(0, 0, 0, 0, 0);
               chk("rb_stall_data",  64'(d1_rb_data), 64'hB);
               chk("rb_stall_valid", 64'(d1_rb_valid), 64'h1);
            end
         end
         step(0, 0, 0, 0, 1);
      end
      step(0, 0, 0, 0, 0);
      chk("rb_end_done", 64'(d1_done), 64'h1);
      chk("rb_end_cfg",  64'(d1_config), 64'hABCD);

      // Corrupted trailer.
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, nib[i], 0, 0);
      cw = c ^ 16'h0001;
      for (int i = 0; i < 4; i++) step(0, 1, cw[15 - 4*i -: 4], 0, 0);
      chk("bad_error",   64'(d1_error), 64'h1);
      chk("bad_core_en", 64'(d1_core_enable), 64'h0);
      chk("bad_cfg",     64'(d1_config), 64'hABCD);

      // Gaps in in_valid.
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         v = (i % 2 == 0);
         step(0, v, v ? nib[i/2] : 4'h7, 0, 0);
         chk("gap_done", 64'(d0_done), 64'(i >= 6));
      end
      chk("gap_cfg",   64'(d0_config), 64'hABCD);
      chk("gap_error", 64'(d0_error), 64'h0);

      // Abort after two beats.
      step(1, 0, 0, 0, 0);
      step(0, 1, 4'h5, 0, 0);
      step(0, 1, 4'h6, 0, 0);
      step(1, 0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) step(0, 1, 4'(i), 0, 0);
      chk("abort_cfg",  64'(d0_config), 64'h1234);
      chk("abort_done", 64'(d0_done), 64'h1);

      // start coincident with a beat discards that beat.
      step(1, 0, 0, 0, 0);
      step(0, 1, 4'h1, 0, 0);
      step(0, 1, 4'h2, 0, 0);
      step(1, 1, 4'hF, 0, 0);
      for (int i = 1; i <= 3; i++) step(0, 1, 4'(i), 0, 0);
      chk("coinc_cfg",  64'(d0_config), 64'h0123);
      chk("coinc_done", 64'(d0_done), 64'h0);
      step(0, 1, 4'h4, 0, 0);
      chk("coinc_cfg2", 64'(d0_config), 64'h1234);

      // Asynchronous reset between edges in the middle of a load.
      step(1, 0, 0, 0, 0);
      step(0, 1, 4'h9, 0, 0);
      step(0, 1, 4'h8, 0, 0);
      in_valid = 1'b0;
      #1 reset = 1'b1;
      #1;
      chk("arst_cfg_n",  64'(d0_config), 64'h0);
      chk("arst_cfg_c",  64'(d1_config), 64'h0);
      chk("arst_busy",   64'(d0_busy), 64'h0);
      chk("arst_ready",  64'(d1_in_ready), 64'h0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) step(0, 1, 4'($urandom), 0, 0);
      chk("idle_cfg",   64'(d0_config), 64'h0);
      chk("idle_busy",  64'(d0_busy), 64'h0);
      chk("idle_ready", 64'(d0_in_ready), 64'h0);

      // Randomized traffic against the model; trailers are mostly correct.
      for (int n = 0; n < 2500; n++) begin
         cw = crc_bits(16'hFFFF, 64'(md_img), 16);
         if (md_mode == M_CRC && $urandom_range(0, 7) != 0) d = cw[15 - 4*md_tn -: 4];
         else d = 4'($urandom);
         step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, d,
              $urandom_range(0, 3) == 0, 1'($urandom));
      end
      step(0, 0, 0, 0, 0);

      // Full-size single-lane load with trailer.
      bg_start = 1'b1;
      tick();
      bg_start = 1'b0;
      bg_valid = 1'b1;
      cb = 16'hFFFF;
      for (int i = 0; i < BIG_W; i++) begin
         b = 1'($urandom);
         bg_data = b;
         exp_big = {exp_big[BIG_W-2:0], b};
         cb = crc_bits(cb, 64'(b), 1);
         tick();
      end
      for (int k = 0; k < 16; k++) begin
         if (k == 15) begin
            chk("big_busy",       64'(bg_busy), 64'h1);
            chk("big_done_early", 64'(bg_done), 64'h0);
         end
         bg_data = cb[15 - k];
         tick();
      end
      bg_valid = 1'b0;
      tick();
      chk("big_done",     64'(bg_done), 64'h1);
      chk("big_core_en",  64'(bg_core_enable), 64'h1);
      chk("big_error",    64'(bg_error), 64'h0);
      chk("big_ready",    64'(bg_in_ready), 64'h0);
      chk("big_rb_valid", 64'(bg_rb_valid), 64'h0);
      chk("big_rb_data",  64'(bg_rb_data), 64'(exp_big[BIG_W-1]));
      chk("big_cfg_eq",   64'(bg_config == exp_big), 64'h1);
      chk("big_cfg_top",  bg_config[BIG_W-1 -: 64], exp_big[BIG_W-1 -: 64]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
